// File: rtl/alu_issue_ctrl.sv
// Issue/control front-end for the datapath ALU: decodes the operation, holds
// operands and control stable for a settle time, then returns the registered result.
module alu_issue_ctrl #(
    parameter int         DATA_WIDTH    = 64,
    parameter int         SETTLE_CYCLES = 1,
    parameter logic [3:0] PARK_CODE     = 4'b1111
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            alu_op,
    input  logic [10:0]           opcode,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic [DATA_WIDTH-1:0] alu_in_1,
    output logic [DATA_WIDTH-1:0] alu_in_2,
    output logic [3:0]            alu_control,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_CAPTURE,
        S_OUT,
        S_PARK
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES);

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_alu_in_1;
    logic [DATA_WIDTH-1:0] r_alu_in_2;
    logic [3:0]            r_alu_control;
    logic                  r_illegal;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_zero;
    logic                  r_out_valid;

    logic [3:0]            w_code;
    logic                  w_dec_illegal;
    logic [DATA_WIDTH-1:0] w_capture;
    logic                  w_in_ready;

    always_comb begin
        w_code        = PARK_CODE;
        w_dec_illegal = 1'b0;
        case (alu_op)
            2'b00: w_code = 4'b0010;
            2'b01: w_code = 4'b0110;
            2'b10: begin
                case (opcode)
                    11'b10001011000: w_code = 4'b0010;
                    11'b11001011000: w_code = 4'b0110;
                    11'b10001010000: w_code = 4'b0000;
                    11'b10101010000: w_code = 4'b0001;
                    default:         w_dec_illegal = 1'b1;
                endcase
            end
            default: w_dec_illegal = 1'b1;
        endcase
    end

    // Illegal requests report zero regardless of what the parked ALU returns.
    assign w_capture  = r_illegal ? '0 : alu_result;
    // Reset must win over a same-cycle request, so ready is masked by reset.
    assign w_in_ready = (r_state == S_IDLE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_alu_in_1    <= '0;
            r_alu_in_2    <= '0;
            r_alu_control <= PARK_CODE;
            r_illegal     <= 1'b0;
            r_result      <= '0;
            r_zero        <= 1'b0;
            r_out_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_alu_in_1    <= operand_a;
                        r_alu_in_2    <= operand_b;
                        r_alu_control <= w_code;
                        r_illegal     <= w_dec_illegal;
                        r_cnt         <= CNT_LOAD;
                        r_state       <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_result    <= w_capture;
                    r_zero      <= (w_capture == '0);
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid   <= 1'b0;
                        r_illegal     <= 1'b0;
                        r_alu_control <= PARK_CODE;
                        r_state       <= S_PARK;
                    end
                end
                S_PARK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = w_in_ready;
    assign alu_in_1    = r_alu_in_1;
    assign alu_in_2    = r_alu_in_2;
    assign alu_control = r_alu_control;
    assign out_valid   = r_out_valid;
    assign result      = r_result;
    assign zero        = r_zero;
    assign illegal     = r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and a result scoreboard.
module tb_alu_issue_ctrl;

    localparam int DW     = 64;
    localparam int SETTLE = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    alu_op;
    logic [10:0]   opcode;
    logic [DW-1:0] operand_a;
    logic [DW-1:0] operand_b;
    logic [DW-1:0] alu_in_1;
    logic [DW-1:0] alu_in_2;
    logic [3:0]    alu_control;
    logic [DW-1:0] alu_result;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic          zero;
    logic          illegal;

    typedef struct {
        logic [DW-1:0] res;
        logic          zr;
        logic          ill;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_WIDTH(DW), .SETTLE_CYCLES(SETTLE), .PARK_CODE(4'b1111)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b),
        .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_control(alu_control),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    // Behavioural datapath ALU
    always_comb begin
        alu_result = '0;
        case (alu_control)
            4'b0010: alu_result = alu_in_1 + alu_in_2;
            4'b0110: alu_result = alu_in_1 - alu_in_2;
            4'b0000: alu_result = alu_in_1 & alu_in_2;
            4'b0001: alu_result = alu_in_1 | alu_in_2;
            default: alu_result = '0;
        endcase
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request with out_ready held high and check it end to end.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [10:0] opc,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [3:0] ectl, input logic [DW-1:0] eres, input logic eill);
        exp_t e;
        int   cnt;
        e.res = eres; e.zr = (eres == '0); e.ill = eill;
        sb.push_back(e);
        out_ready = 1'b1;
        alu_op = op; opcode = opc; operand_a = a; operand_b = b; in_valid = 1'b1;
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_accept_timeout"}, 64'(cnt < 20), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        operand_a = ~a; operand_b = ~b;
        check({tag, "_ctrl_drive"}, 64'(alu_control), 64'(ectl));
        check({tag, "_in1_drive"}, alu_in_1, a);
        check({tag, "_in_ready_drive"}, 64'(in_ready), 64'd0);
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_latency"}, 64'(cnt), 64'(SETTLE + 2));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'(sb.size()));
        end else begin
            e = sb.pop_front();
            check({tag, "_result"}, result, e.res);
            check({tag, "_zero"}, 64'(zero), 64'(e.zr));
            check({tag, "_illegal"}, 64'(illegal), 64'(e.ill));
        end
        @(negedge clk);
        check({tag, "_park_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_park_ctrl"}, 64'(alu_control), 64'hF);
        check({tag, "_park_ready"}, 64'(in_ready), 64'd0);
        @(negedge clk);
        check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int cnt;
        int seen;
        logic [DW-1:0] held;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = '0; opcode = '0; operand_a = '0; operand_b = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        check("rst_ctrl", 64'(alu_control), 64'hF);
        check("rst_in1", alu_in_1, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(in_ready), 64'd1);

        do_op("radd", 2'b10, 11'b10001011000, 64'd5, 64'd7, 4'b0010, 64'd12, 1'b0);
        do_op("sub0", 2'b01, 11'b00000000000, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 4'b0110, 64'd0, 1'b0);
        do_op("rand", 2'b10, 11'b10001010000, 64'hFF00, 64'h0FF0, 4'b0000, 64'h0F00, 1'b0);
        do_op("rorr", 2'b10, 11'b10101010000, 64'hFF00, 64'h0FF0, 4'b0001, 64'hFFF0, 1'b0);
        do_op("ill_opc", 2'b10, 11'b11111111111, 64'd3, 64'd4, 4'b1111, 64'd0, 1'b1);
        do_op("ill_op11", 2'b11, 11'b10001011000, 64'd9, 64'd1, 4'b1111, 64'd0, 1'b1);
        do_op("ldst", 2'b00, 11'b11001011000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'b0010, 64'd1, 1'b0);
        do_op("rsub", 2'b10, 11'b11001011000, 64'd100, 64'd1, 4'b0110, 64'd99, 1'b0);

        // Backpressure: hold out_ready low with activity on the inputs.
        out_ready = 1'b0;
        alu_op = 2'b00; operand_a = 64'd40; operand_b = 64'd2; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("bp_latency", 64'(cnt), 64'(SETTLE + 2));
        held = 64'd42;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            operand_a = 64'(i * 17); operand_b = 64'(i + 3);
            @(negedge clk);
            check("bp_result", result, held);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_ctrl", 64'(alu_control), 64'h2);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_park_valid", 64'(out_valid), 64'd0);
        check("bp_park_ctrl", 64'(alu_control), 64'hF);
        @(negedge clk);
        check("bp_idle_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("bp_nothing_queued", 64'(seen), 64'd0);

        // Reset during DRIVE aborts the operation.
        alu_op = 2'b00; operand_a = 64'd8; operand_b = 64'd8; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("abort_drive_ctrl", 64'(alu_control), 64'h2);
        reset = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_ctrl", 64'(alu_control), 64'hF);
        check("abort_result", result, 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("abort_no_accept_ctrl", 64'(alu_control), 64'hF);
        in_valid = 1'b0;
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_output", 64'(seen), 64'd0);
        do_op("after_abort", 2'b00, 11'b0, 64'd20, 64'd22, 4'b0010, 64'd42, 1'b0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
